// File: rtl/conv1d_relu_maxpool.sv
// ReLU + non-overlapping max pooling + requantization to 0..127.
// One output position per beat, KERNELS channels in parallel.
module conv1d_relu_maxpool #(
    parameter int KERNELS   = 4,
    parameter int POOL_SIZE = 2,
    parameter int SHIFT     = 4,
    parameter int CNT_BITS  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [KERNELS*16-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KERNELS*8-1:0]  out_data,
    output logic                  out_last,
    output logic [CNT_BITS-1:0]   win_count,
    output logic                  sat_flag
);
    localparam int PW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [PW-1:0] POS_END = PW'(POOL_SIZE - 1);

    logic [PW-1:0]               pos_q, pos_d;
    logic [KERNELS-1:0][15:0]    max_q, max_d;
    logic                        out_valid_q, out_valid_d;
    logic [KERNELS*8-1:0]        out_data_q, out_data_d;
    logic                        out_last_q, out_last_d;
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;
    logic                        sat_q, sat_d;

    logic                        accept, xfer, close;
    logic [KERNELS-1:0][15:0]    m_new;
    logic [KERNELS*8-1:0]        q_new;
    logic [KERNELS-1:0]          sat_new;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign close    = accept && ((pos_q == POS_END) || in_last);

    // Per-channel ReLU, running max including this beat, and requant.
    always_comb begin
        m_new   = '0;
        q_new   = '0;
        sat_new = '0;
        for (int k = 0; k < KERNELS; k++) begin
            logic [15:0] x, r, s;
            x = in_data[16*k +: 16];
            r = x[15] ? 16'd0 : x;
            if (pos_q == '0 || r > max_q[k]) m_new[k] = r;
            else                             m_new[k] = max_q[k];
            s = m_new[k] >> SHIFT;
            sat_new[k] = (s > 16'd127);
            q_new[8*k +: 8] = sat_new[k] ? 8'd127 : s[7:0];
        end
    end

    always_comb begin
        pos_d       = pos_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        if (clear) begin
            pos_d       = '0;
            max_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = '0;
            sat_d       = 1'b0;
        end else begin
            if (accept) max_d = m_new;
            if (close) begin
                pos_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = q_new;
                out_last_d  = in_last;
                cnt_d       = cnt_q + 1'b1;
                sat_d       = sat_q || (|sat_new);
            end else begin
                if (accept) pos_d = pos_q + 1'b1;
                if (xfer)   out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign win_count = cnt_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_conv1d_relu_maxpool.sv
// Directed bench for conv1d_relu_maxpool (KERNELS=4, POOL_SIZE=2, SHIFT=4).
// Expected values are hand-computed constants.
module tb_conv1d_relu_maxpool;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic [6:0]  win_count;
    logic        sat_flag;

    int nassert = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    conv1d_relu_maxpool #(
        .KERNELS(4), .POOL_SIZE(2), .SHIFT(4), .CNT_BITS(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .win_count(win_count), .sat_flag(sat_flag)
    );

    function automatic logic [63:0] pk(input int c0, input int c1,
                                       input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, return 1ns after the edge.
    task automatic send(input logic [63:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_last",  32'(out_last), 32'd0);
        chk("rst_win_count", 32'(win_count), 32'd0);
        chk("rst_sat_flag",  32'(sat_flag), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ch0 100,200 ch1 320,16 ch2 -50,-3 ch3 -32768,48
        send(pk(100, 320, -50, -32768), 1'b0);
        chk("w1_no_early_valid", 32'(out_valid), 32'd0);
        send(pk(200, 16, -3, 48), 1'b0);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data",  out_data, {8'd3, 8'd0, 8'd20, 8'd12});
        chk("w1_last",  32'(out_last), 32'd0);
        chk("w1_count", 32'(win_count), 32'd1);
        chk("w1_sat",   32'(sat_flag), 32'd0);

        // Saturation: 4000>>4 = 250 -> 127
        send(pk(4000, 0, 0, 0), 1'b0);
        send(pk(10, 0, 0, 0), 1'b0);
        chk("w2_data",  out_data, 32'd127);
        chk("w2_sat",   32'(sat_flag), 32'd1);
        chk("w2_count", 32'(win_count), 32'd2);

        // 16,32 then 80 with last: partial window emitted
        send(pk(16, 0, 0, 0), 1'b0);
        send(pk(32, 0, 0, 0), 1'b0);
        chk("w3_data", out_data, 32'd2);
        chk("w3_last", 32'(out_last), 32'd0);
        send(pk(80, 0, 0, 0), 1'b1);
        chk("w4_valid", 32'(out_valid), 32'd1);
        chk("w4_data",  out_data, 32'd5);
        chk("w4_last",  32'(out_last), 32'd1);
        chk("w4_count", 32'(win_count), 32'd4);
        chk("w4_sat_sticky", 32'(sat_flag), 32'd1);
        @(posedge clk); #1;
        chk("w4_drained", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        send(pk(160, 0, 0, 0), 1'b0);
        send(pk(48, 0, 0, 0), 1'b0);
        chk("st_data", out_data, 32'd10);
        in_valid = 1'b1;
        in_data  = pk(1600, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("st_in_ready", 32'(in_ready), 32'd0);
            chk("st_valid",    32'(out_valid), 32'd1);
            chk("st_hold",     out_data, 32'd10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("st_release", 32'(out_valid), 32'd0);
        send(pk(32, 0, 0, 0), 1'b0);
        chk("st_after_valid", 32'(out_valid), 32'd1);
        chk("st_after_data",  out_data, 32'd100);
        chk("st_after_count", 32'(win_count), 32'd6);

        // Async reset mid-window
        send(pk(200, 0, 0, 0), 1'b0);
        #2 rst_n = 1'b0;
        #2;
        chk("mr_count", 32'(win_count), 32'd0);
        chk("mr_sat",   32'(sat_flag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(pk(64, 0, 0, 0), 1'b0);
        send(pk(32, 0, 0, 0), 1'b0);
        chk("mr_data",  out_data, 32'd4);
        chk("mr_count1", 32'(win_count), 32'd1);

        // clear with a pending output
        send(pk(16, 0, 0, 0), 1'b0);
        out_ready = 1'b0;
        send(pk(16, 0, 0, 0), 1'b1);
        chk("cl_pre_valid", 32'(out_valid), 32'd1);
        chk("cl_pre_count", 32'(win_count), 32'd2);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("cl_valid", 32'(out_valid), 32'd0);
        chk("cl_count", 32'(win_count), 32'd0);
        chk("cl_last",  32'(out_last), 32'd0);
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
